// File: rtl/life_pkg.sv
// Shared definitions for the Life board loader.
// Holds the default board geometry, the flat board width and the
// loader state enumeration used by the top level.
package life_pkg;

  localparam int LIFE_ROWS = 16;
  localparam int LIFE_COLS = 16;
  localparam int BOARD_W   = LIFE_ROWS * LIFE_COLS;

  // Loader control states
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FREEZE = 3'd1,
    ST_STEP   = 3'd2,
    ST_FILL   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/life_row_shadow.sv
// Shadow register file that assembles an incoming board image row by row.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset, clears the whole image
//   we     - write enable for one row
//   idx    - row index written when we=1
//   row    - row bits (bit j is column j)
//   shadow - flat image, row r at [COLS*r +: COLS]
module life_row_shadow
  import life_pkg::*;
#(
  parameter int ROWS = LIFE_ROWS,
  parameter int COLS = LIFE_COLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] idx,
  input  logic [COLS-1:0]         row,
  output logic [ROWS*COLS-1:0]    shadow
);

  logic [ROWS*COLS-1:0] shadow_r;

  // Row write port; rows not addressed keep their contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r <= '0;
    end else if (we) begin
      shadow_r[COLS*int'(idx) +: COLS] <= row;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign shadow = shadow_r;

endmodule

// File: rtl/life_board_loader.sv
// Control and pattern-load stage in front of the toroidal Life board.
// Collects a new image over a row stream into a shadow buffer, commits it
// to the board in one cycle, and runs, freezes or single-steps evolution.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   row_valid/row_data/row_first/row_ready - image row stream
//   run, step              - evolve level and single-step pulse
//   board_q                - board state fed back from the board
//   load, data             - board load control and load data
//   gen_count              - generations advanced since last commit/reset
//   seq_err                - sticky stream protocol violation flag
module life_board_loader
  import life_pkg::*;
#(
  parameter int ROWS  = LIFE_ROWS,
  parameter int COLS  = LIFE_COLS,
  parameter int GEN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 row_valid,
  input  logic [COLS-1:0]      row_data,
  input  logic                 row_first,
  output logic                 row_ready,
  input  logic                 run,
  input  logic                 step,
  input  logic [ROWS*COLS-1:0] board_q,
  output logic                 load,
  output logic [ROWS*COLS-1:0] data,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 seq_err
);

  localparam int              IDX_W    = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_t                 state_r;
  state_t                 state_s;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_s;
  logic [GEN_W-1:0]       gen_r;
  logic                   seq_err_r;
  logic                   seq_set_s;
  logic                   shadow_we_s;
  logic [IDX_W-1:0]       shadow_idx_s;
  logic [ROWS*COLS-1:0]   shadow_s;
  logic                   load_s;
  logic                   ready_s;
  logic                   accept_s;

  life_row_shadow #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (shadow_we_s),
    .idx    (shadow_idx_s),
    .row    (row_data),
    .shadow (shadow_s)
  );

  // Moore decode of board load and stream ready from the state register
  always_comb begin
    load_s  = 1'b1;
    ready_s = 1'b1;
    case (state_r)
      ST_RUN:    begin load_s = 1'b0; ready_s = 1'b1; end
      ST_FREEZE: begin load_s = 1'b1; ready_s = 1'b1; end
      ST_STEP:   begin load_s = 1'b0; ready_s = 1'b0; end
      ST_FILL:   begin load_s = 1'b1; ready_s = 1'b1; end
      ST_COMMIT: begin load_s = 1'b1; ready_s = 1'b0; end
      default:   begin load_s = 1'b1; ready_s = 1'b0; end
    endcase
  end

  assign accept_s = row_valid & ready_s;

  // Next-state, row index and shadow write control
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    shadow_we_s  = 1'b0;
    shadow_idx_s = idx_r;
    seq_set_s    = 1'b0;
    case (state_r)
      ST_RUN, ST_FREEZE: begin
        if (accept_s && row_first) begin
          // A new image start wins over run/step
          state_s      = ST_FILL;
          shadow_we_s  = 1'b1;
          shadow_idx_s = '0;
          idx_s        = IDX_W'(1);
        end else begin
          // A beat without row_first here is dropped and flagged
          seq_set_s = accept_s;
          if (state_r == ST_RUN) begin
            state_s = run ? ST_RUN : ST_FREEZE;
          end else if (run) begin
            state_s = ST_RUN;
          end else if (step) begin
            state_s = ST_STEP;
          end else begin
            state_s = ST_FREEZE;
          end
        end
      end
      ST_STEP: begin
        state_s = run ? ST_RUN : ST_FREEZE;
      end
      ST_FILL: begin
        if (accept_s) begin
          shadow_we_s = 1'b1;
          if (row_first) begin
            // Restart the image from row 0
            shadow_idx_s = '0;
            idx_s        = IDX_W'(1);
            seq_set_s    = 1'b1;
            state_s      = ST_FILL;
          end else begin
            shadow_idx_s = idx_r;
            idx_s        = idx_r + IDX_W'(1);
            state_s      = (idx_r == LAST_IDX) ? ST_COMMIT : ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_COMMIT: begin
        idx_s   = '0;
        state_s = run ? ST_RUN : ST_FREEZE;
      end
      default: begin
        state_s = ST_FREEZE;
        idx_s   = '0;
      end
    endcase
  end

  // State and row index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FREEZE;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Generation counter: cleared by a commit, counts every cycle the board evolves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_r <= '0;
    end else if (state_r == ST_COMMIT) begin
      gen_r <= '0;
    end else if (!load_s) begin
      gen_r <= gen_r + GEN_W'(1);
    end else begin
      gen_r <= gen_r;
    end
  end

  // Sticky protocol error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err_r <= 1'b0;
    end else if (seq_set_s) begin
      seq_err_r <= 1'b1;
    end else begin
      seq_err_r <= seq_err_r;
    end
  end

  // Combinational data mux so frozen feedback has no lag
  assign data      = (state_r == ST_COMMIT) ? shadow_s : board_q;
  assign load      = load_s;
  assign row_ready = ready_s;
  assign gen_count = gen_r;
  assign seq_err   = seq_err_r;

endmodule
